// File: rtl/bp_update_queue.sv
// In-order predictor update queue: buffers {index, predicted direction} and emits one registered
// predictor write per resolution. Optional statistics counters are enabled by BP_UPDATE_QUEUE_STATS_EN.
module bp_update_queue #(
   parameter int  IDX_W = 32,
   parameter int  DEPTH = 8,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             pred_valid_i,
   input  logic [IDX_W-1:0] pred_idx_i,
   input  logic             pred_taken_i,
   output logic             pred_ready_o,
   input  logic             res_valid_i,
   input  logic             res_taken_i,
   input  logic             flush_i,
   output logic             upd_valid_o,
   output logic [IDX_W-1:0] w_idx_o,
   output logic             br_result_o,
   output logic             mispredict_o,
   output logic             underflow_o,
   output logic [CNT_W-1:0] count_o,
   output logic [31:0]      mispred_cnt_o,
   output logic [31:0]      branch_cnt_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [IDX_W-1:0] r_mem_idx [DEPTH];
   logic [DEPTH-1:0] r_mem_taken;
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic             r_upd_valid;
   logic [IDX_W-1:0] r_w_idx;
   logic             r_br_result;
   logic             r_mispredict;
   logic             r_underflow;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_underflow;
   logic             w_mis;

   // Flush overrides everything, including a same-cycle resolution.
   always_comb begin
      w_full      = (r_count == CNT_W'(DEPTH));
      w_empty     = (r_count == '0);
      w_push      = pred_valid_i && !w_full && !flush_i;
      w_pop       = res_valid_i && !w_empty && !flush_i;
      w_underflow = res_valid_i && w_empty && !flush_i;
      w_mis       = r_mem_taken[r_head] ^ res_taken_i;
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem_idx[r_tail]   <= pred_idx_i;
         r_mem_taken[r_tail] <= pred_taken_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + PTR_W'(1);
         if (w_pop)  r_head <= r_head + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      end
   end

   // Data outputs hold their last update; only the valid and underflow flags pulse.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_upd_valid  <= 1'b0;
         r_w_idx      <= '0;
         r_br_result  <= 1'b0;
         r_mispredict <= 1'b0;
         r_underflow  <= 1'b0;
      end else begin
         r_upd_valid <= w_pop;
         r_underflow <= w_underflow;
         if (w_pop) begin
            r_w_idx      <= r_mem_idx[r_head];
            r_br_result  <= res_taken_i;
            r_mispredict <= w_mis;
         end
      end
   end

`ifdef BP_UPDATE_QUEUE_STATS_EN
   logic [31:0] r_branch_cnt;
   logic [31:0] r_mispred_cnt;

   // Counted at retirement so they line up with the update they describe; flush leaves them alone.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_branch_cnt  <= '0;
         r_mispred_cnt <= '0;
      end else if (w_pop) begin
         if (r_branch_cnt != '1)           r_branch_cnt  <= r_branch_cnt + 32'd1;
         if (w_mis && r_mispred_cnt != '1) r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
   end

   assign branch_cnt_o  = r_branch_cnt;
   assign mispred_cnt_o = r_mispred_cnt;
`else
   assign branch_cnt_o  = '0;
   assign mispred_cnt_o = '0;
`endif

   assign pred_ready_o = !w_full;
   assign upd_valid_o  = r_upd_valid;
   assign w_idx_o      = r_w_idx;
   assign br_result_o  = r_br_result;
   assign mispredict_o = r_mispredict;
   assign underflow_o  = r_underflow;
   assign count_o      = r_count;

endmodule

// File: tb/tb_bp_update_queue.sv
// Self-checking bench for bp_update_queue: directed vector table, hand sequences and
// random traffic compared against a queue-based reference model.
module tb_bp_update_queue;

   localparam int IDX_W = 32;
   localparam int DEPTH = 8;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             pred_valid;
   logic [IDX_W-1:0] pred_idx;
   logic             pred_taken;
   logic             pred_ready;
   logic             res_valid;
   logic             res_taken;
   logic             flush;
   logic             upd_valid;
   logic [IDX_W-1:0] w_idx;
   logic             br_result;
   logic             mispredict;
   logic             underflow;
   logic [CNT_W-1:0] count;
   logic [31:0]      mispred_cnt;
   logic [31:0]      branch_cnt;

   bp_update_queue #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .pred_valid_i(pred_valid), .pred_idx_i(pred_idx), .pred_taken_i(pred_taken),
      .pred_ready_o(pred_ready),
      .res_valid_i(res_valid), .res_taken_i(res_taken), .flush_i(flush),
      .upd_valid_o(upd_valid), .w_idx_o(w_idx), .br_result_o(br_result),
      .mispredict_o(mispredict), .underflow_o(underflow), .count_o(count),
      .mispred_cnt_o(mispred_cnt), .branch_cnt_o(branch_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IDX_W-1:0] idx;
      logic             taken;
   } entry_t;

   entry_t           m_q[$];
   logic             m_upd, m_res, m_mis, m_unf;
   logic [IDX_W-1:0] m_idx;
   logic [31:0]      m_bcnt, m_mcnt;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Drives one cycle of inputs, advances the reference model and samples 1 time unit after the edge.
   task automatic step(input logic rst, input logic pv, input logic [IDX_W-1:0] pidx, input logic pt,
                       input logic rv, input logic rt, input logic fl);
      int     sz;
      entry_t e;
      rst_n = rst; pred_valid = pv; pred_idx = pidx; pred_taken = pt;
      res_valid = rv; res_taken = rt; flush = fl;
      sz = m_q.size();
      if (!rst) begin
         m_q.delete();
         m_upd = 0; m_idx = '0; m_res = 0; m_mis = 0; m_unf = 0; m_bcnt = 0; m_mcnt = 0;
      end else if (fl) begin
         m_q.delete();
         m_upd = 0; m_unf = 0;
      end else begin
         m_upd = 0; m_unf = 0;
         if (rv && sz > 0) begin
            e = m_q.pop_front();
            m_upd = 1; m_idx = e.idx; m_res = rt; m_mis = (e.taken != rt);
            if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
            if (m_mis && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
         end else if (rv) begin
            m_unf = 1;
         end
         if (pv && sz != DEPTH) m_q.push_back('{idx: pidx, taken: pt});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_model();
      chk("upd_valid", 64'(upd_valid), 64'(m_upd));
      chk("w_idx", 64'(w_idx), 64'(m_idx));
      chk("br_result", 64'(br_result), 64'(m_res));
      chk("mispredict", 64'(mispredict), 64'(m_mis));
      chk("underflow", 64'(underflow), 64'(m_unf));
      chk("count", 64'(count), 64'(m_q.size()));
      chk("pred_ready", 64'(pred_ready), 64'(m_q.size() != DEPTH));
`ifdef BP_UPDATE_QUEUE_STATS_EN
      chk("branch_cnt", 64'(branch_cnt), 64'(m_bcnt));
      chk("mispred_cnt", 64'(mispred_cnt), 64'(m_mcnt));
`else
      chk("branch_cnt", 64'(branch_cnt), 64'd0);
      chk("mispred_cnt", 64'(mispred_cnt), 64'd0);
`endif
   endtask

   typedef struct {
      logic pv; logic [IDX_W-1:0] pidx; logic pt; logic rv; logic rt; logic fl;
      logic e_upd; logic [IDX_W-1:0] e_idx; logic e_res; logic e_mis; logic e_unf;
      logic [CNT_W-1:0] e_cnt; logic e_rdy;
   } vec_t;

   vec_t tbl[7];

   initial begin
      logic [31:0] exp_b, exp_m;
      tbl[0] = '{1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1};
      tbl[1] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1};
      tbl[2] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1};
      tbl[3] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1};
      tbl[4] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1};
      tbl[5] = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1};
      tbl[6] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1};

      // Reset held two cycles under random inputs
      for (int i = 0; i < 2; i++)
         step(1'b0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk("rst_upd", 64'(upd_valid), 64'd0);
      chk("rst_idx", 64'(w_idx), 64'd0);
      chk("rst_res", 64'(br_result), 64'd0);
      chk("rst_mis", 64'(mispredict), 64'd0);
      chk("rst_unf", 64'(underflow), 64'd0);
      chk("rst_cnt", 64'(count), 64'd0);
      chk("rst_rdy", 64'(pred_ready), 64'd1);
      chk("rst_bcnt", 64'(branch_cnt), 64'd0);
      chk("rst_mcnt", 64'(mispred_cnt), 64'd0);

      // Single branch, empty resolve, push with same-cycle empty resolve
      for (int i = 0; i < 7; i++) begin
         step(1'b1, tbl[i].pv, tbl[i].pidx, tbl[i].pt, tbl[i].rv, tbl[i].rt, tbl[i].fl);
         chk($sformatf("vec%0d_upd", i), 64'(upd_valid), 64'(tbl[i].e_upd));
         chk($sformatf("vec%0d_idx", i), 64'(w_idx), 64'(tbl[i].e_idx));
         chk($sformatf("vec%0d_res", i), 64'(br_result), 64'(tbl[i].e_res));
         chk($sformatf("vec%0d_mis", i), 64'(mispredict), 64'(tbl[i].e_mis));
         chk($sformatf("vec%0d_unf", i), 64'(underflow), 64'(tbl[i].e_unf));
         chk($sformatf("vec%0d_cnt", i), 64'(count), 64'(tbl[i].e_cnt));
         chk($sformatf("vec%0d_rdy", i), 64'(pred_ready), 64'(tbl[i].e_rdy));
      end

      // Fill, drop when full, drain with interleaved pushes across the wrap
      step(1'b1, 0, '0, 0, 0, 0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, IDX_W'(i), 1'($urandom), 0, 0, 0);
      chk("fill_cnt", 64'(count), 64'd8);
      chk("fill_rdy", 64'(pred_ready), 64'd0);
      step(1'b1, 1'b1, IDX_W'(8), 1'b1, 0, 0, 0);
      chk("drop_cnt", 64'(count), 64'd8);
      check_model();
      for (int k = 0; k < 8; k++) begin
         step(1'b1, (k >= 1 && k <= 4), IDX_W'(8 + k), 1'($urandom), 1'b1, 1'($urandom), 0);
         chk("wrap_upd", 64'(upd_valid), 64'd1);
         chk("wrap_idx", 64'(w_idx), 64'(k));
         check_model();
      end
      chk("wrap_cnt", 64'(count), 64'd4);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 0, '0, 0, 1'b1, 1'($urandom), 0);
         chk("wrap2_idx", 64'(w_idx), 64'(9 + k));
         check_model();
      end

      // Simultaneous push and pop at count 3
      step(1'b1, 0, '0, 0, 0, 0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, IDX_W'(32'h100 + i), 1'($urandom), 0, 0, 0);
      step(1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 0);
      chk("sim_cnt", 64'(count), 64'd3);
      chk("sim_upd", 64'(upd_valid), 64'd1);
      chk("sim_idx", 64'(w_idx), 64'h100);
      check_model();

      // Flush with same-cycle resolve, then resolve on the empty queue
      step(1'b1, 0, '0, 0, 0, 0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, IDX_W'(32'h300 + i), 1'($urandom), 0, 0, 0);
      step(1'b1, 0, '0, 0, 1'b1, 1'b0, 1'b1);
      chk("flush_upd", 64'(upd_valid), 64'd0);
      chk("flush_cnt", 64'(count), 64'd0);
      step(1'b1, 0, '0, 0, 1'b1, 1'b0, 0);
      chk("flush_unf", 64'(underflow), 64'd1);
      chk("flush_upd2", 64'(upd_valid), 64'd0);

      // Statistics: 10 retirements, 3 mispredicts, flush leaves counters intact
      step(1'b0, 0, '0, 0, 0, 0, 0);
      for (int j = 0; j < 10; j++) begin
         step(1'b1, 1'b1, IDX_W'(j), 1'b1, 0, 0, 0);
         step(1'b1, 0, '0, 0, 1'b1, !(j == 2 || j == 5 || j == 7), 0);
      end
`ifdef BP_UPDATE_QUEUE_STATS_EN
      exp_b = 32'd10; exp_m = 32'd3;
`else
      exp_b = 32'd0;  exp_m = 32'd0;
`endif
      chk("stat_bcnt", 64'(branch_cnt), 64'(exp_b));
      chk("stat_mcnt", 64'(mispred_cnt), 64'(exp_m));
      step(1'b1, 1'b1, 32'h5, 1'b0, 0, 0, 1'b1);
      chk("stat_bcnt_flush", 64'(branch_cnt), 64'(exp_b));
      chk("stat_mcnt_flush", 64'(mispred_cnt), 64'(exp_m));

      // Random traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, $urandom, 1'($urandom),
              $urandom_range(0, 9) < 5, 1'($urandom), $urandom_range(0, 29) == 0);
         check_model();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
